// File: rtl/fpu_interco_pkg.sv
// Shared types and defaults for the FPU core arbiter and its ID FIFO.
// The default widths match a 4-core cluster.
package fpu_interco_pkg;

    localparam int DEF_NB_CORES        = 4;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_FP_TYPE_WIDTH   = 5;
    localparam int DEF_NB_ARGS         = 3;
    localparam int DEF_OPCODE_WIDTH    = 6;
    localparam int DEF_DSFLAGS_CPU     = 15;
    localparam int DEF_USFLAGS_CPU     = 5;
    localparam int DEF_MAX_OUTSTANDING = 4;

    localparam logic [DEF_FP_TYPE_WIDTH-1:0] FPNEW_ID = 5'd0;
    localparam logic [DEF_FP_TYPE_WIDTH-1:0] APU_ID   = 5'd1;

    localparam int CORE_ID_W = $clog2(DEF_NB_CORES);
    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef struct packed {
        logic [DEF_FP_TYPE_WIDTH-1:0]                 fp_type;
        logic [DEF_NB_ARGS-1:0][DEF_DATA_WIDTH-1:0]   operands;
        logic [DEF_OPCODE_WIDTH-1:0]                  op;
        logic [DEF_DSFLAGS_CPU-1:0]                   flags;
    } fpu_req_t;

    // Wraps an index that may be up to 2*n-2 back into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fpu_arb_id_fifo.sv
// In-order FIFO of granted core IDs. The head falls through to the incoming
// ID when empty so a same-cycle response can be routed without storage.
module fpu_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [ID_W-1:0] push_id_i,
    input  logic            pop_i,
    output logic [ID_W-1:0] head_o,
    output logic            bypass_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]  wr_q, wr_d, rd_q, rd_d;
    logic [ID_W-1:0] mem_q [DEPTH];
    logic [ID_W-1:0] mem_d [DEPTH];
    logic            do_push, do_pop;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                      (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign bypass_o = empty_o & push_i;
    assign head_o   = empty_o ? push_id_i : mem_q[rd_q[PTR_W-1:0]];

    // A push and pop on an empty FIFO is a pass-through: neither pointer moves.
    assign do_push = push_i & ~(empty_o & pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_d  = wr_q + {{PTR_W{1'b0}}, do_push};
        rd_d  = rd_q + {{PTR_W{1'b0}}, do_pop};
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q[PTR_W-1:0]] = push_id_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fpu_core_arbiter.sv
// Round-robin arbiter of NB_CORES FP request ports onto one FPU port, with
// in-order response routing. Optional stall counter: FPU_ARB_PERF_CNT_EN.
module fpu_core_arbiter
    import fpu_interco_pkg::*;
#(
    parameter int NB_CORES        = DEF_NB_CORES,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int FP_TYPE_WIDTH   = DEF_FP_TYPE_WIDTH,
    parameter int NB_ARGS         = DEF_NB_ARGS,
    parameter int OPCODE_WIDTH    = DEF_OPCODE_WIDTH,
    parameter int DSFLAGS_CPU     = DEF_DSFLAGS_CPU,
    parameter int USFLAGS_CPU     = DEF_USFLAGS_CPU,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NB_CORES-1:0]                           core_req_i,
    output logic [NB_CORES-1:0]                           core_gnt_o,
    input  logic [NB_CORES-1:0][FP_TYPE_WIDTH-1:0]        core_type_i,
    input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]         core_op_i,
    input  logic [NB_CORES-1:0][DSFLAGS_CPU-1:0]          core_flags_i,
    input  logic [NB_CORES-1:0]                           core_rready_i,
    output logic [NB_CORES-1:0]                           core_rvalid_o,
    output logic [NB_CORES-1:0][DATA_WIDTH-1:0]           core_rdata_o,
    output logic [NB_CORES-1:0][USFLAGS_CPU-1:0]          core_rflags_o,
    output logic                                          fpu_req_o,
    input  logic                                          fpu_gnt_i,
    output logic [FP_TYPE_WIDTH-1:0]                      fpu_type_o,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]            fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                       fpu_op_o,
    output logic [DSFLAGS_CPU-1:0]                        fpu_flags_o,
    output logic                                          fpu_rready_o,
    input  logic                                          fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                         fpu_rdata_i,
    input  logic [USFLAGS_CPU-1:0]                        fpu_rflags_i
`ifdef FPU_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                                   stall_cnt_o
`endif
);

    localparam int ID_W = $clog2(NB_CORES);

    typedef struct packed {
        logic [FP_TYPE_WIDTH-1:0]             fp_type;
        logic [NB_ARGS-1:0][DATA_WIDTH-1:0]   operands;
        logic [OPCODE_WIDTH-1:0]              op;
        logic [DSFLAGS_CPU-1:0]               flags;
    } req_t;

    req_t            core_req_s [NB_CORES];
    req_t            win_req;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] win, cand, dest;
    logic            found, handshake, dest_valid, pop;
    logic            fifo_full, fifo_empty, fifo_bypass;

    genvar gi;
    generate
        for (gi = 0; gi < NB_CORES; gi++) begin : g_core
            assign core_req_s[gi]    = '{core_type_i[gi], core_operands_i[gi],
                                         core_op_i[gi], core_flags_i[gi]};
            assign core_rdata_o[gi]  = fpu_rdata_i;
            assign core_rflags_o[gi] = fpu_rflags_i;
        end
    endgenerate

    // First requester at or after rr_ptr, in wrap-around order.
    always_comb begin
        win   = rr_ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NB_CORES; i++) begin
            cand = ID_W'(rr_wrap(int'(rr_ptr_q) + i, NB_CORES));
            if (!found && core_req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_req        = core_req_s[win];
    assign fpu_type_o     = win_req.fp_type;
    assign fpu_operands_o = win_req.operands;
    assign fpu_op_o       = win_req.op;
    assign fpu_flags_o    = win_req.flags;

    assign fpu_req_o  = (|core_req_i) & ~fifo_full;
    assign handshake  = fpu_req_o & fpu_gnt_i;
    assign core_gnt_o = handshake ? (NB_CORES'(1) << win) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = ID_W'(rr_wrap(int'(win) + 1, NB_CORES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    fpu_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (handshake),
        .push_id_i (win),
        .pop_i     (pop),
        .head_o    (dest),
        .bypass_o  (fifo_bypass),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign dest_valid    = ~fifo_empty | fifo_bypass;
    assign fpu_rready_o  = dest_valid & core_rready_i[dest];
    assign core_rvalid_o = (dest_valid & fpu_rvalid_i) ? (NB_CORES'(1) << dest) : '0;
    assign pop           = fpu_rvalid_i & fpu_rready_o;

`ifdef FPU_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|core_req_i) && !handshake && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fpu_rvalid_i && !dest_valid));
            assert (int'(rr_ptr_q) < NB_CORES);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_core_arbiter.sv
// Randomized and directed bench for fpu_core_arbiter against a queue-based
// model of round-robin grants and in-order response routing.
module tb_fpu_core_arbiter;

    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic [NC-1:0]               core_req, core_gnt, core_rready, core_rvalid;
    logic [NC-1:0][4:0]          core_type;
    logic [NC-1:0][2:0][31:0]    core_operands;
    logic [NC-1:0][5:0]          core_op;
    logic [NC-1:0][14:0]         core_flags;
    logic [NC-1:0][31:0]         core_rdata;
    logic [NC-1:0][4:0]          core_rflags;
    logic                        fpu_req, fpu_gnt, fpu_rready, fpu_rvalid;
    logic [4:0]                  fpu_type, fpu_rflags;
    logic [2:0][31:0]            fpu_operands;
    logic [5:0]                  fpu_op;
    logic [14:0]                 fpu_flags;
    logic [31:0]                 fpu_rdata;
`ifdef FPU_ARB_PERF_CNT_EN
    logic [31:0]                 stall_cnt;
`endif

    fpu_core_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .core_req_i      (core_req),
        .core_gnt_o      (core_gnt),
        .core_type_i     (core_type),
        .core_operands_i (core_operands),
        .core_op_i       (core_op),
        .core_flags_i    (core_flags),
        .core_rready_i   (core_rready),
        .core_rvalid_o   (core_rvalid),
        .core_rdata_o    (core_rdata),
        .core_rflags_o   (core_rflags),
        .fpu_req_o       (fpu_req),
        .fpu_gnt_i       (fpu_gnt),
        .fpu_type_o      (fpu_type),
        .fpu_operands_o  (fpu_operands),
        .fpu_op_o        (fpu_op),
        .fpu_flags_o     (fpu_flags),
        .fpu_rready_o    (fpu_rready),
        .fpu_rvalid_i    (fpu_rvalid),
        .fpu_rdata_i     (fpu_rdata),
        .fpu_rflags_i    (fpu_rflags)
`ifdef FPU_ARB_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding grants as a plain queue of core numbers.
    int         q[$];
    int         rr;
    int         win, dest;
    int         stall_model;
    logic       exp_req, exp_rready;
    logic [3:0] exp_gnt, exp_rvalid;

    task automatic model_eval();
        int idx;
        win = -1;
        for (int i = 0; i < NC; i++) begin
            idx = (rr + i) % NC;
            if (win < 0 && core_req[idx[1:0]]) win = idx;
        end
        exp_req = (win >= 0) && (q.size() < 4);
        exp_gnt = (exp_req && fpu_gnt) ? (4'b0001 << win) : 4'b0000;
        if (q.size() > 0)             dest = q[0];
        else if (exp_req && fpu_gnt)  dest = win;
        else                          dest = -1;
        exp_rready = (dest >= 0) ? core_rready[dest[1:0]] : 1'b0;
        exp_rvalid = (dest >= 0 && fpu_rvalid) ? (4'b0001 << dest) : 4'b0000;
    endtask

    task automatic tick();
        model_eval();
        if (core_req != 0 && !(exp_req && fpu_gnt)) stall_model++;
        if (exp_req && fpu_gnt) begin
            q.push_back(win);
            rr = (win + 1) % NC;
        end
        if (dest >= 0 && fpu_rvalid && exp_rready) void'(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req      = '0;
        core_rready   = 4'b1111;
        core_type     = '0;
        core_operands = '0;
        core_op       = '0;
        core_flags    = '0;
        fpu_gnt       = 1'b0;
        fpu_rvalid    = 1'b0;
        fpu_rdata     = '0;
        fpu_rflags    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        q.delete();
        rr = 0;
        stall_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        core_rready = '0;
        #2;
        checks++;
        if (core_gnt !== 4'b0000 || core_rvalid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_core_outs gnt=%b rvalid=%b required 0000/0000", core_gnt, core_rvalid);
        end
        checks++;
        if (fpu_req !== 1'b0 || fpu_rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_fpu_outs req=%b rready=%b required 0/0", fpu_req, fpu_rready);
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_single_core();
        do_reset();
        core_req = 4'b0001;
        core_operands[0] = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        fpu_gnt = 1'b1;
        #1;
        checks++;
        if (core_gnt !== 4'b0001 || fpu_operands !== core_operands[0]) begin
            errors++;
            $display("FAIL single_grant gnt=%b ops=%h required 0001 ops=%h", core_gnt, fpu_operands, core_operands[0]);
        end
        tick();
        core_req = '0;
        fpu_gnt  = 1'b0;
        #1;
        checks++;
        if (core_rvalid !== 4'b0000 || fpu_rready !== 1'b1) begin
            errors++;
            $display("FAIL single_wait rvalid=%b rready=%b required 0000/1", core_rvalid, fpu_rready);
        end
        tick();
        fpu_rvalid = 1'b1;
        fpu_rdata  = 32'h3F80_0000;
        #1;
        checks++;
        if (core_rvalid !== 4'b0001 || core_rdata[0] !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL single_resp rvalid=%b rdata=%h required 0001/3f800000", core_rvalid, core_rdata[0]);
        end
        tick();
        fpu_rvalid = 1'b0;
        #1;
        checks++;
        if (fpu_rready !== 1'b0) begin
            errors++;
            $display("FAIL single_empty rready=%b required 0", fpu_rready);
        end
        $display("test_single_core done");
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        core_req   = 4'b1111;
        fpu_gnt    = 1'b1;
        fpu_rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (core_gnt !== (4'b0001 << order[i]) || core_rvalid !== (4'b0001 << order[i])) begin
                errors++;
                $display("FAIL rr_order step=%0d gnt=%b rvalid=%b required core %0d", i, core_gnt, core_rvalid, order[i]);
            end
            tick();
        end
        idle_inputs();
        $display("test_round_robin done");
    endtask

    task automatic test_zero_latency();
        do_reset();
        core_req   = 4'b0100;
        fpu_gnt    = 1'b1;
        fpu_rvalid = 1'b1;
        #1;
        checks++;
        if (core_rvalid !== 4'b0100 || core_gnt !== 4'b0100 || fpu_rready !== 1'b1) begin
            errors++;
            $display("FAIL zero_lat rvalid=%b gnt=%b rready=%b required 0100/0100/1", core_rvalid, core_gnt, fpu_rready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (fpu_rready !== 1'b0 || fpu_req !== 1'b0) begin
            errors++;
            $display("FAIL zero_lat_empty rready=%b req=%b required 0/0", fpu_rready, fpu_req);
        end
        $display("test_zero_latency done");
    endtask

    task automatic test_full();
        do_reset();
        core_req = 4'b1111;
        fpu_gnt  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fpu_req !== 1'b1 || core_gnt !== (4'b0001 << i)) begin
                errors++;
                $display("FAIL full_fill step=%0d req=%b gnt=%b required 1/core %0d", i, fpu_req, core_gnt, i);
            end
            tick();
        end
        #1;
        checks++;
        if (fpu_req !== 1'b0 || core_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL full_mask req=%b gnt=%b required 0/0000", fpu_req, core_gnt);
        end
        fpu_rvalid = 1'b1;
        #1;
        checks++;
        if (core_rvalid !== 4'b0001 || fpu_req !== 1'b0) begin
            errors++;
            $display("FAIL full_resp rvalid=%b req=%b required 0001/0", core_rvalid, fpu_req);
        end
        tick();
        fpu_rvalid = 1'b0;
        fpu_gnt    = 1'b0;
        #1;
        checks++;
        if (fpu_req !== 1'b1) begin
            errors++;
            $display("FAIL full_reassert req=%b required 1", fpu_req);
        end
        $display("test_full done");
    endtask

    // Continues from test_full: outstanding cores 1,2,3.
    task automatic test_backpressure();
        int guard = 0;
        core_req    = '0;
        fpu_gnt     = 1'b0;
        fpu_rvalid  = 1'b1;
        core_rready = 4'b1101;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (core_rvalid !== 4'b0010 || fpu_rready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc=%0d rvalid=%b rready=%b required 0010/0", i, core_rvalid, fpu_rready);
            end
            tick();
        end
        core_rready = 4'b1111;
        while (q.size() > 0 && guard < 10) begin
            model_eval();
            #1;
            checks++;
            if (core_rvalid !== exp_rvalid || fpu_rready !== 1'b1) begin
                errors++;
                $display("FAIL drain cyc=%0d rvalid=%b rready=%b required %b/1", guard, core_rvalid, fpu_rready, exp_rvalid);
            end
            tick();
            guard++;
        end
        checks++;
        if (guard != 3) begin
            errors++;
            $display("FAIL drain_count drained=%0d required 3", guard);
        end
        fpu_rvalid = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_error_path();
        do_reset();
        core_req     = 4'b0010;
        core_type[1] = 5'd7;
        fpu_gnt      = 1'b1;
        #1;
        checks++;
        if (fpu_type !== 5'd7 || core_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL err_grant type=%0d gnt=%b required 7/0010", fpu_type, core_gnt);
        end
        tick();
        core_req   = '0;
        fpu_gnt    = 1'b0;
        fpu_rvalid = 1'b1;
        fpu_rdata  = 32'hBADF_7ACC;
        #1;
        checks++;
        if (core_rvalid !== 4'b0010 || core_rdata[1] !== 32'hBADF_7ACC) begin
            errors++;
            $display("FAIL err_resp rvalid=%b rdata=%h required 0010/badf7acc", core_rvalid, core_rdata[1]);
        end
        tick();
        fpu_rvalid = 1'b0;
        $display("test_error_path done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        core_req = 4'b1111;
        fpu_gnt  = 1'b1;
        tick();
        tick();
        core_req   = '0;
        fpu_gnt    = 1'b0;
        rst_n      = 1'b0;
        fpu_rvalid = 1'b1;
        #1;
        checks++;
        if (core_rvalid !== 4'b0000 || fpu_rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid rvalid=%b rready=%b required 0000/0", core_rvalid, fpu_rready);
        end
        fpu_rvalid = 1'b0;
        do_reset();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            core_req      = 4'($urandom_range(0, 15));
            fpu_gnt       = 1'($urandom_range(0, 3) != 0);
            core_rready   = 4'($urandom_range(0, 15));
            for (int i = 0; i < NC; i++) begin
                core_type[i]     = 5'($urandom);
                core_operands[i] = {$urandom, $urandom, $urandom};
                core_op[i]       = 6'($urandom);
                core_flags[i]    = 15'($urandom);
            end
            fpu_rdata  = $urandom;
            fpu_rflags = 5'($urandom);
            model_eval();
            fpu_rvalid = (dest >= 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            model_eval();
            k = $urandom_range(0, NC - 1);
            #1;
            checks++;
            if (core_gnt !== exp_gnt || fpu_req !== exp_req) begin
                errors++;
                $display("FAIL rand_arb cyc=%0d gnt=%b req=%b required %b/%b", c, core_gnt, fpu_req, exp_gnt, exp_req);
            end
            checks++;
            if (core_rvalid !== exp_rvalid || fpu_rready !== exp_rready) begin
                errors++;
                $display("FAIL rand_resp cyc=%0d rvalid=%b rready=%b required %b/%b", c, core_rvalid, fpu_rready, exp_rvalid, exp_rready);
            end
            checks++;
            if (core_rdata[k] !== fpu_rdata || core_rflags[k] !== fpu_rflags) begin
                errors++;
                $display("FAIL rand_bcast cyc=%0d core=%0d data=%h flags=%h required %h/%h", c, k, core_rdata[k], core_rflags[k], fpu_rdata, fpu_rflags);
            end
            if (exp_req) begin
                checks++;
                if (fpu_op !== core_op[win[1:0]] || fpu_type !== core_type[win[1:0]] ||
                    fpu_flags !== core_flags[win[1:0]] || fpu_operands !== core_operands[win[1:0]]) begin
                    errors++;
                    $display("FAIL rand_payload cyc=%0d op=%h type=%h required op=%h type=%h (core %0d)", c, fpu_op, fpu_type, core_op[win[1:0]], core_type[win[1:0]], win);
                end
            end
            tick();
        end
`ifdef FPU_ARB_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'(stall_model)) begin
            errors++;
            $display("FAIL stall_cnt actual=%0d required %0d", stall_cnt, stall_model);
        end
`endif
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        q.delete();
        rr = 0;
        stall_model = 0;
        test_reset();
        test_single_core();
        test_round_robin();
        test_zero_latency();
        test_full();
        test_backpressure();
        test_error_path();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
